// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: one RV32I memory access at a time over a
// req/ack bus, with lane steering, load extension and error reporting.
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [4:0]  mem_rd,
   output logic        stall,
   output logic        done,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        misalign_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wrdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rddata
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [4:0]  rd_q;
   logic [7:0]  cnt_q;
   logic        misalign_q;
   logic        bus_err_q;
   logic        bad_in;
   logic        timeout_hit;
   logic [1:0]  off;
   logic [3:0]  be;
   logic [31:0] wr_sh;
   logic [31:0] ext;

   assign off         = addr_q[1:0];
   assign timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

   // Misaligned or illegal width, judged on the incoming instruction
   always_comb begin
      bad_in = 1'b1;
      case (mem_funct3)
         3'b000:         bad_in = 1'b0;
         3'b001:         bad_in = mem_addr[0];
         3'b101:         bad_in = mem_addr[0] | mem_we;
         3'b010:         bad_in = (mem_addr[1:0] != 2'b00);
         3'b100:         bad_in = mem_we;
         default:        bad_in = 1'b1;
      endcase
   end

   always_comb begin
      be    = 4'b1111;
      wr_sh = wdata_q;
      case (f3_q[1:0])
         2'b00: begin be = 4'b0001 << off; wr_sh = wdata_q << {off, 3'b000}; end
         2'b01: begin be = 4'b0011 << off; wr_sh = wdata_q << {off, 3'b000}; end
         default: begin be = 4'b1111; wr_sh = wdata_q; end
      endcase
   end

   // rdata_q is already shifted down to lane 0 at capture time
   always_comb begin
      ext = rdata_q;
      case (f3_q)
         3'b000:  ext = {{24{rdata_q[7]}}, rdata_q[7:0]};
         3'b001:  ext = {{16{rdata_q[15]}}, rdata_q[15:0]};
         3'b100:  ext = {24'd0, rdata_q[7:0]};
         3'b101:  ext = {16'd0, rdata_q[15:0]};
         default: ext = rdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      stall        = mem_valid & (state != DONE) & ~rst;
      bus_req      = 1'b0;
      bus_we       = 1'b0;
      bus_addr     = 32'd0;
      bus_be       = 4'd0;
      bus_wrdata   = 32'd0;
      done         = 1'b0;
      rf_we        = 1'b0;
      rf_waddr     = 5'd0;
      rf_wdata     = 32'd0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
      case (state)
         IDLE: begin
            if (mem_valid) state_nx = bad_in ? DONE : BUS;
         end
         BUS: begin
            bus_req    = 1'b1;
            bus_we     = we_q;
            bus_addr   = {addr_q[31:2], 2'b00};
            bus_be     = be;
            bus_wrdata = wr_sh;
            if (bus_ack || timeout_hit) state_nx = DONE;
         end
         DONE: begin
            done         = 1'b1;
            rf_waddr     = rd_q;
            misalign_err = misalign_q;
            bus_err      = bus_err_q;
            if (!we_q && !misalign_q && !bus_err_q) begin
               rf_we    = (rd_q != 5'd0);
               rf_wdata = ext;
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         rd_q       <= 5'd0;
         cnt_q      <= 8'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  we_q       <= mem_we;
                  f3_q       <= mem_funct3;
                  addr_q     <= mem_addr;
                  wdata_q    <= mem_wdata;
                  rd_q       <= mem_rd;
                  rdata_q    <= 32'd0;
                  cnt_q      <= 8'd0;
                  misalign_q <= bad_in;
                  bus_err_q  <= 1'b0;
               end
            end
            BUS: begin
               if (bus_ack)          rdata_q   <= bus_rddata >> {off, 3'b000};
               else if (timeout_hit) bus_err_q <= 1'b1;
               else                  cnt_q     <= cnt_q + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: loads, stores, misaligned/illegal accesses,
// bus timeout, rd=0, reset mid-access and back-to-back instructions.
module tb_lsu_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_we = 1'b0;
   logic [2:0]  mem_funct3 = 3'd0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [4:0]  mem_rd = 5'd0;
   logic        stall, done, rf_we, misalign_err, bus_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wrdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rddata = 32'd0;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] cap_addr, cap_wrdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   int          req_n, stall_n;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
      .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .stall(stall), .done(done), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misalign_err(misalign_err),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wrdata(bus_wrdata), .bus_ack(bus_ack),
      .bus_rddata(bus_rddata)
   );

   always #5 clk = ~clk;

   localparam logic [2:0]  LD_F3  [6] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b010, 3'b000};
   localparam logic [31:0] LD_AD  [6] = '{32'h103, 32'h102, 32'h102, 32'h101, 32'h104, 32'h100};
   localparam logic [31:0] LD_RD  [6] = '{32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF,
                                          32'h0000_F000, 32'h1234_5678, 32'h0000_007F};
   localparam logic [3:0]  LD_BE  [6] = '{4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b1111, 4'b0001};
   localparam logic [31:0] LD_BA  [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h100};
   localparam logic [31:0] LD_EXP [6] = '{32'hFFFF_FF80, 32'hFFFF_8001, 32'h0000_8001,
                                          32'h0000_00F0, 32'h1234_5678, 32'h0000_007F};

   localparam logic [2:0]  ST_F3 [3] = '{3'b001, 3'b000, 3'b010};
   localparam logic [31:0] ST_AD [3] = '{32'h202, 32'h201, 32'h300};
   localparam logic [31:0] ST_WD [3] = '{32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_F00D};
   localparam logic [3:0]  ST_BE [3] = '{4'b1100, 4'b0010, 4'b1111};
   localparam logic [31:0] ST_SH [3] = '{32'hABCD_0000, 32'h3456_7800, 32'hCAFE_F00D};
   localparam logic [31:0] ST_BA [3] = '{32'h200, 32'h200, 32'h300};

   localparam logic        MA_WE [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic [2:0]  MA_F3 [5] = '{3'b010, 3'b100, 3'b001, 3'b011, 3'b010};
   localparam logic [31:0] MA_AD [5] = '{32'h101, 32'h100, 32'h103, 32'h100, 32'h302};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      mem_valid  = 1'b1;
      mem_we     = we;
      mem_funct3 = f3;
      mem_addr   = addr;
      mem_wdata  = wdata;
      mem_rd     = rd;
      #1;
   endtask

   task automatic release_req();
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      tick();
   endtask

   // Starts in the accept cycle, ends at the DONE cycle (or when the budget runs out).
   // ack_at = N acks in the N-th BUS cycle; 0 never acks.
   task automatic run_access(input int ack_at, input logic [31:0] rdata);
      req_n   = 0;
      stall_n = 0;
      for (int c = 0; c < 40; c++) begin
         if (done) break;
         if (stall) stall_n++;
         if (bus_req) begin
            if (req_n == 0) begin
               cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wrdata = bus_wrdata;
            end
            req_n++;
            if (req_n == ack_at) begin
               bus_ack = 1'b1; bus_rddata = rdata;
            end
         end
         tick();
         bus_ack    = 1'b0;
         bus_rddata = 32'd0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({stall, done, bus_req, bus_we, bus_addr, bus_be, bus_wrdata, rf_we, rf_waddr,
           rf_wdata, misalign_err, bus_err} !== '0) begin
         n_err++; $display("FAIL reset_outputs: got nonzero output (req=%b done=%b stall=%b)", bus_req, done, stall);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_loads();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, LD_F3[i], LD_AD[i], 32'h5555_5555, 5'(5 + i));
         run_access(1, LD_RD[i]);
         n_vec++; if (cap_addr !== LD_BA[i]) begin n_err++; $display("FAIL load_addr[%0d]: got %h exp %h", i, cap_addr, LD_BA[i]); end
         n_vec++; if (cap_be !== LD_BE[i]) begin n_err++; $display("FAIL load_be[%0d]: got %b exp %b", i, cap_be, LD_BE[i]); end
         n_vec++; if (cap_we !== 1'b0) begin n_err++; $display("FAIL load_we[%0d]: got %b exp 0", i, cap_we); end
         n_vec++; if (req_n != 1 || stall_n != 2) begin n_err++; $display("FAIL load_latency[%0d]: req %0d stall %0d exp 1 2", i, req_n, stall_n); end
         n_vec++; if ({done, stall, rf_we, misalign_err, bus_err} !== 5'b10100) begin n_err++; $display("FAIL load_done[%0d]: got %b exp 10100", i, {done, stall, rf_we, misalign_err, bus_err}); end
         n_vec++; if (rf_waddr !== 5'(5 + i)) begin n_err++; $display("FAIL load_waddr[%0d]: got %0d exp %0d", i, rf_waddr, 5 + i); end
         n_vec++; if (rf_wdata !== LD_EXP[i]) begin n_err++; $display("FAIL load_wdata[%0d]: got %h exp %h", i, rf_wdata, LD_EXP[i]); end
         release_req();
         n_vec++; if ({done, rf_we, rf_wdata} !== '0) begin n_err++; $display("FAIL load_after[%0d]: done %b rf_we %b", i, done, rf_we); end
      end
   endtask

   task automatic test_stores();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ST_F3[i], ST_AD[i], ST_WD[i], 5'd7);
         run_access(1, 32'hFFFF_FFFF);
         n_vec++; if (cap_we !== 1'b1) begin n_err++; $display("FAIL store_we[%0d]: got %b exp 1", i, cap_we); end
         n_vec++; if (cap_be !== ST_BE[i]) begin n_err++; $display("FAIL store_be[%0d]: got %b exp %b", i, cap_be, ST_BE[i]); end
         n_vec++; if (cap_wrdata !== ST_SH[i]) begin n_err++; $display("FAIL store_wrdata[%0d]: got %h exp %h", i, cap_wrdata, ST_SH[i]); end
         n_vec++; if (cap_addr !== ST_BA[i]) begin n_err++; $display("FAIL store_addr[%0d]: got %h exp %h", i, cap_addr, ST_BA[i]); end
         n_vec++; if ({done, rf_we, rf_wdata, misalign_err, bus_err} !== {1'b1, 35'd0}) begin n_err++; $display("FAIL store_done[%0d]: done %b rf_we %b wdata %h", i, done, rf_we, rf_wdata); end
         release_req();
      end
   endtask

   task automatic test_misalign();
      for (int i = 0; i < 5; i++) begin
         drive(MA_WE[i], MA_F3[i], MA_AD[i], 32'h1111_2222, 5'd9);
         run_access(1, 32'h1234_5678);
         n_vec++; if (req_n != 0 || stall_n != 1) begin n_err++; $display("FAIL misalign_latency[%0d]: req %0d stall %0d exp 0 1", i, req_n, stall_n); end
         n_vec++; if ({done, misalign_err, bus_err, rf_we, stall} !== 5'b11000) begin n_err++; $display("FAIL misalign_done[%0d]: got %b exp 11000", i, {done, misalign_err, bus_err, rf_we, stall}); end
         n_vec++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL misalign_wdata[%0d]: got %h exp 0", i, rf_wdata); end
         release_req();
         n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_clear[%0d]: got %b exp 0", i, misalign_err); end
      end
   endtask

   task automatic test_timeout();
      drive(1'b0, 3'b101, 32'h302, 32'd0, 5'd12);
      run_access(0, 32'd0);
      n_vec++; if (req_n != TO) begin n_err++; $display("FAIL timeout_req: got %0d exp %0d", req_n, TO); end
      n_vec++; if ({done, bus_err, misalign_err, rf_we, rf_wdata} !== {2'b11, 34'd0}) begin n_err++; $display("FAIL timeout_done: done %b bus_err %b rf_we %b", done, bus_err, rf_we); end
      release_req();
      n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b exp 0", bus_err); end
      drive(1'b0, 3'b101, 32'h302, 32'd0, 5'd12);
      run_access(TO, 32'h9ABC_1111);
      n_vec++; if (req_n != TO) begin n_err++; $display("FAIL late_ack_req: got %0d exp %0d", req_n, TO); end
      n_vec++; if ({done, bus_err, rf_we} !== 3'b101) begin n_err++; $display("FAIL late_ack_done: got %b exp 101", {done, bus_err, rf_we}); end
      n_vec++; if (rf_wdata !== 32'h0000_9ABC) begin n_err++; $display("FAIL late_ack_wdata: got %h exp 00009abc", rf_wdata); end
      release_req();
   endtask

   task automatic test_rd_zero();
      drive(1'b0, 3'b010, 32'h400, 32'd0, 5'd0);
      run_access(1, 32'hDEAD_BEEF);
      n_vec++; if ({done, rf_we, bus_err, misalign_err} !== 4'b1000) begin n_err++; $display("FAIL rd_zero: got %b exp 1000", {done, rf_we, bus_err, misalign_err}); end
      release_req();
   endtask

   task automatic test_ack_outside_bus();
      bus_ack = 1'b1; bus_rddata = 32'hFFFF_FFFF;
      tick();
      tick();
      n_vec++; if ({done, bus_req, rf_we, stall} !== 4'b0000) begin n_err++; $display("FAIL stray_ack: got %b exp 0000", {done, bus_req, rf_we, stall}); end
      bus_ack = 1'b0; bus_rddata = 32'd0;
   endtask

   task automatic test_reset_mid_access();
      drive(1'b0, 3'b010, 32'h500, 32'd0, 5'd3);
      tick();
      n_vec++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL midrst_pre: bus_req %b exp 1", bus_req); end
      rst = 1'b1;
      #1;
      n_vec++;
      if ({stall, done, bus_req, bus_we, bus_addr, bus_be, bus_wrdata, rf_we, rf_waddr,
           rf_wdata, misalign_err, bus_err} !== '0) begin
         n_err++; $display("FAIL midrst_outputs: req %b stall %b addr %h", bus_req, stall, bus_addr);
      end
      mem_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      drive(1'b0, 3'b000, 32'h103, 32'd0, 5'd4);
      run_access(1, 32'h7F00_0000);
      n_vec++; if ({done, rf_we, rf_wdata} !== {2'b11, 32'h0000_007F}) begin n_err++; $display("FAIL midrst_recover: done %b rf_we %b wdata %h", done, rf_we, rf_wdata); end
      release_req();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 3'b010, 32'h600, 32'h0BAD_F00D, 5'd0);
      run_access(1, 32'd0);
      n_vec++; if ({done, stall, cap_wrdata} !== {2'b10, 32'h0BAD_F00D}) begin n_err++; $display("FAIL b2b_first: done %b wrdata %h", done, cap_wrdata); end
      drive(1'b0, 3'b001, 32'h602, 32'd0, 5'd20);
      tick();
      n_vec++; if ({done, stall, bus_req} !== 3'b010) begin n_err++; $display("FAIL b2b_idle: got %b exp 010", {done, stall, bus_req}); end
      run_access(1, 32'hFEDC_0000);
      n_vec++; if (req_n != 1 || stall_n != 2) begin n_err++; $display("FAIL b2b_latency: req %0d stall %0d exp 1 2", req_n, stall_n); end
      n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd20, 32'hFFFF_FEDC}) begin n_err++; $display("FAIL b2b_second: rf_we %b waddr %0d wdata %h", rf_we, rf_waddr, rf_wdata); end
      release_req();
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_misalign();
      test_timeout();
      test_rd_zero();
      test_ack_outside_bus();
      test_reset_mid_access();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencing controller between the RV32I decode/execute stage and the data bus. Accepts one memory instruction at a time and stalls the core while the access is outstanding. Drives a req/ack bus transaction with correct byte enables and lane-shifted write data. Returns sign- or zero-extended, lane-aligned load data with a one-cycle register-file write strobe, and flags misaligned accesses, illegal width codes and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, number of BUS-state cycles without bus_ack before the access is aborted with bus_err (valid range 1..255)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_valid  in  1  current instruction is a load or store; held until done
mem_we  in  1  1=store, 0=load
mem_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load only)
mem_addr  in  32  effective byte address (ALU output)
mem_wdata  in  32  store data, rs2
mem_rd  in  5  load destination register
stall  out  1  hold PC/pipeline
done  out  1  one-cycle completion pulse
rf_we  out  1  register-file write strobe
rf_waddr  out  5  write register index
rf_wdata  out  32  extended load data
misalign_err  out  1  misaligned or illegal-width access, valid with done
bus_err  out  1  bus timeout, valid with done
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  32  word-aligned address, mem_addr with [1:0]=00
bus_be  out  4  byte enables
bus_wrdata  out  32  lane-shifted store data
bus_ack  in  1  bus completion; rddata valid in the same cycle
bus_rddata  in  32  bus read word

Behaviour:
- States: IDLE, BUS, DONE. Reset: state=IDLE; all outputs 0; internal registers 0. Reset asserted mid-access drops bus_req immediately; the access is abandoned.
- stall = mem_valid & (state != DONE), combinational.
- IDLE: on mem_valid, latch we/funct3/addr/wdata/rd.
  - Misaligned or illegal width goes to DONE with misalign_err=1 and no bus cycle. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=00. Illegal width means funct3 is 011/110/111, or a store with funct3 100/101.
  - Otherwise go to BUS and clear the timeout counter.
- BUS: bus_req=1. bus_we, bus_addr, bus_be and bus_wrdata come from the latched values and stay stable until ack.
  - Byte enables, with off=addr[1:0]: B gives be=0001<<off. H gives be=0011<<off. W gives be=1111.
  - bus_wrdata = wdata<<(8*off) for B/H; unmodified for W.
  - On bus_ack: capture bus_rddata>>(8*off) and go to DONE.
  - Without ack the counter increments. When it reaches TIMEOUT_CYCLES-1 with no ack, go to DONE with bus_err=1. Ack in that same cycle wins, with no error.
- DONE, one cycle, registered outputs:
  - done=1 and stall=0; next state is IDLE.
  - rf_we=1 only for an error-free load with rd!=0. rf_waddr=rd.
  - rf_wdata: B gives sign-extended [7:0]; H gives sign-extended [15:0]; W unchanged; BU/HU zero-extended.
  - Stores and errored accesses give rf_we=0 and rf_wdata=0.
  - Error flags are 1 only in the DONE cycle.
- A new mem_valid is only sampled in IDLE. The instruction retires in DONE, so back-to-back accesses each take the full sequence.
- Minimum latency, ack in the first BUS cycle: accept cycle, BUS cycle, DONE cycle, i.e. 3 cycles with stall high for 2. A misaligned access takes 2 cycles.
- bus_req is never asserted outside BUS. Ignore bus_ack outside BUS.

Test Plan:
- LB addr=0x103, bus_rddata=0x80FF_1234, ack in the first BUS cycle, rd=5 -> bus_addr=0x100, be=1000. DONE: rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80. Stall high for exactly 2 cycles.
- SH addr=0x202, wdata=0x0000_ABCD -> bus_we=1, be=1100, bus_wrdata=0xABCD_0000. DONE with rf_we=0.
- LW addr=0x101 -> no bus_req. Next cycle: done=1, misalign_err=1, rf_we=0. Also SB with funct3=100 -> misalign_err=1.
- LHU addr=0x302 with ack withheld, TIMEOUT_CYCLES=4 -> bus_req high 4 cycles, then done=1, bus_err=1, rf_we=0. Repeat with ack on the 4th cycle -> no error, data written.
- LW to rd=0, rddata=0xDEAD_BEEF -> done=1, rf_we=0. Then assert rst during BUS of the next load -> bus_req, stall-related state and all outputs 0 immediately, state IDLE.
